// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: N-master arbiter and RAM/IO address decoder for the
// byte-wide cpumc memory bus.
//
// Optional feature macro: MEM_BUS_ARBITER_RR_EN
//   defined   -> round-robin arbitration with a rotating priority pointer
//   undefined -> fixed priority, lowest requesting index wins
//
// Handshake: a master presents m_req together with its address, m_wr,
// write data and m_lock, and holds them until it sees m_gnt. The cycle
// m_gnt is high is the issue cycle; the slave is driven in that same
// cycle. In the following cycle m_ack is high for that master and m_din
// carries read data. rdy_in=0 blocks new grants but never cancels an ack
// that is already owed.
module mem_bus_arbiter #(
    parameter int NUM_MASTERS    = 2,
    parameter int ADDR_WIDTH     = 32,
    parameter int RAM_ADDR_WIDTH = 17,
    parameter int IO_SEL_WIDTH   = 3
) (
    input  logic                              clk_in,
    input  logic                              rst_in,
    input  logic                              rdy_in,
    input  logic [NUM_MASTERS-1:0]            m_req,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_a,
    input  logic [NUM_MASTERS-1:0]            m_wr,
    input  logic [NUM_MASTERS*8-1:0]          m_dout,
    input  logic [NUM_MASTERS-1:0]            m_lock,
    output logic [NUM_MASTERS-1:0]            m_gnt,
    output logic [NUM_MASTERS-1:0]            m_ack,
    output logic [7:0]                        m_din,
    output logic                              ram_en,
    output logic                              ram_r_nw,
    output logic [RAM_ADDR_WIDTH-1:0]         ram_a,
    output logic [7:0]                        ram_d_in,
    input  logic [7:0]                        ram_d_out,
    output logic                              io_en,
    output logic [IO_SEL_WIDTH-1:0]           io_sel,
    output logic                              io_wr,
    output logic [7:0]                        io_din,
    input  logic [7:0]                        io_dout
);

    localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    logic                   lock_q;
    logic [IDX_W-1:0]       owner_q;
    logic [NUM_MASTERS-1:0] ack_q;
    logic                   ack_io_q;
    logic [NUM_MASTERS-1:0] eligible;
    logic                   gnt_any;
    logic [IDX_W-1:0]       gnt_idx;
    logic [ADDR_WIDTH-1:0]  sel_a;
    logic                   sel_wr;
    logic [7:0]             sel_dout;
    logic                   is_io;

`ifdef MEM_BUS_ARBITER_RR_EN
    logic [IDX_W-1:0]       ptr_q;
`endif

    // While locked, only the lock owner may compete for the bus.
    always_comb begin
        eligible = m_req;
        if (lock_q) begin
            eligible          = '0;
            eligible[owner_q] = m_req[owner_q];
        end
    end

`ifdef MEM_BUS_ARBITER_RR_EN
    // Round-robin pick: first eligible index at or after the pointer.
    always_comb begin
        int cand;
        cand    = 0;
        gnt_any = 1'b0;
        gnt_idx = '0;
        if (rdy_in && !rst_in) begin
            for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
                cand = (int'(ptr_q) + k) % NUM_MASTERS;
                if (eligible[cand]) begin
                    gnt_any = 1'b1;
                    gnt_idx = IDX_W'(cand);
                end
            end
        end
    end

    // Pointer moves just past the winner after every grant.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            ptr_q <= '0;
        end else if (gnt_any) begin
            ptr_q <= (gnt_idx == IDX_W'(NUM_MASTERS - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end
`else
    // Fixed priority pick: lowest eligible index wins.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        if (rdy_in && !rst_in) begin
            for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
                if (eligible[k]) begin
                    gnt_any = 1'b1;
                    gnt_idx = IDX_W'(k);
                end
            end
        end
    end
`endif

    // Steer the winner's request to RAM or to the IO window.
    always_comb begin
        sel_a    = m_a[int'(gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wr   = m_wr[gnt_idx];
        sel_dout = m_dout[int'(gnt_idx)*8 +: 8];
        is_io    = (sel_a[RAM_ADDR_WIDTH -: 2] == 2'b11);
        m_gnt    = gnt_any ? (NUM_MASTERS'(1) << gnt_idx) : '0;
        ram_en   = gnt_any && !is_io;
        io_en    = gnt_any && is_io;
        io_wr    = gnt_any && is_io && sel_wr;
        ram_r_nw = (gnt_any && !is_io) ? !sel_wr : 1'b1;
        ram_a    = sel_a[RAM_ADDR_WIDTH-1:0];
        io_sel   = sel_a[IO_SEL_WIDTH-1:0];
        ram_d_in = sel_dout;
        io_din   = sel_dout;
    end

    // Response side: the read mux follows the registered issue-cycle IO flag.
    always_comb begin
        m_ack = rst_in ? '0 : ack_q;
        m_din = 8'h00;
        if (!rst_in && (ack_q != '0)) begin
            m_din = ack_io_q ? io_dout : ram_d_out;
        end
    end

    // Remember who issued this cycle and which slave answers next cycle.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            ack_q    <= '0;
            ack_io_q <= 1'b0;
        end else begin
            ack_q    <= m_gnt;
            ack_io_q <= io_en;
        end
    end

    // Lock is taken on a locked issue and dropped once the owner lets go.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            lock_q  <= 1'b0;
            owner_q <= '0;
        end else if (gnt_any && m_lock[gnt_idx]) begin
            lock_q  <= 1'b1;
            owner_q <= gnt_idx;
        end else if (lock_q && !m_lock[owner_q]) begin
            lock_q  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed bench for mem_bus_arbiter with a RAM and
// IO slave model and a cycle-level reference model of the bus rules.
module tb_mem_bus_arbiter;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic [1:0]  m_req;
    logic [63:0] m_a;
    logic [1:0]  m_wr;
    logic [15:0] m_dout;
    logic [1:0]  m_lock;
    logic [1:0]  m_gnt;
    logic [1:0]  m_ack;
    logic [7:0]  m_din;
    logic        ram_en;
    logic        ram_r_nw;
    logic [16:0] ram_a;
    logic [7:0]  ram_d_in;
    logic [7:0]  ram_d_out;
    logic        io_en;
    logic [2:0]  io_sel;
    logic        io_wr;
    logic [7:0]  io_din;
    logic [7:0]  io_dout;

    int total = 0;
    int bad   = 0;

    mem_bus_arbiter #(
        .NUM_MASTERS(2), .ADDR_WIDTH(32), .RAM_ADDR_WIDTH(17), .IO_SEL_WIDTH(3)
    ) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .m_req(m_req), .m_a(m_a), .m_wr(m_wr), .m_dout(m_dout), .m_lock(m_lock),
        .m_gnt(m_gnt), .m_ack(m_ack), .m_din(m_din),
        .ram_en(ram_en), .ram_r_nw(ram_r_nw), .ram_a(ram_a), .ram_d_in(ram_d_in),
        .ram_d_out(ram_d_out),
        .io_en(io_en), .io_sel(io_sel), .io_wr(io_wr), .io_din(io_din), .io_dout(io_dout)
    );

    // Clock and slave models
    always #5 clk_in = ~clk_in;

    logic [7:0] mem     [0:131071];
    logic [7:0] io_regs [0:7];
    logic [7:0] exp_mem [0:131071];
    logic [7:0] exp_io  [0:7];

    always @(posedge clk_in) begin
        if (ram_en) begin
            if (ram_r_nw) ram_d_out <= mem[ram_a];
            else          mem[ram_a] <= ram_d_in;
        end
        if (io_en) begin
            if (io_wr) io_regs[io_sel] <= io_din;
            else       io_dout <= io_regs[io_sel];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: who must win, what the slaves must see, what returns next cycle
    logic        md_locked = 1'b0;
    int          md_owner  = 0;
    int          md_ptr    = 0;
    logic [1:0]  md_pend_ack = 2'b00;
    logic        md_pend_rd  = 1'b0;
    logic [7:0]  md_pend_data = 8'h00;

    always @(negedge clk_in) begin : model
        logic [1:0]  elig;
        logic [31:0] addr;
        logic        wr;
        logic        io;
        int          g;
        int          start;
        int          c;
        elig = md_locked ? (m_req & (2'b01 << md_owner)) : m_req;
`ifdef MEM_BUS_ARBITER_RR_EN
        start = md_ptr;
`else
        start = 0;
`endif
        g = -1;
        if (!rst_in && rdy_in) begin
            for (int k = 0; k < 2; k++) begin
                c = (start + k) % 2;
                if (g < 0 && elig[c]) g = c;
            end
        end
        addr = (g == 1) ? m_a[63:32] : m_a[31:0];
        wr   = (g == 1) ? m_wr[1] : m_wr[0];
        io   = (addr[17:16] == 2'b11);

        chk("gnt", 32'(m_gnt), (g < 0) ? 32'd0 : (32'd1 << g));
        chk("ram_en", 32'(ram_en), 32'(g >= 0 && !io));
        chk("io_en", 32'(io_en), 32'(g >= 0 && io));
        chk("io_wr", 32'(io_wr), 32'(g >= 0 && io && wr));
        chk("ram_r_nw", 32'(ram_r_nw), 32'((g >= 0 && !io) ? !wr : 1'b1));
        if (g >= 0 && !io) chk("ram_a", 32'(ram_a), 32'(addr[16:0]));
        if (g >= 0 && io) chk("io_sel", 32'(io_sel), 32'(addr[2:0]));
        if (g >= 0 && wr) begin
            if (io) chk("io_din", 32'(io_din), 32'((g == 1) ? m_dout[15:8] : m_dout[7:0]));
            else    chk("ram_d_in", 32'(ram_d_in), 32'((g == 1) ? m_dout[15:8] : m_dout[7:0]));
        end
        chk("ack", 32'(m_ack), rst_in ? 32'd0 : 32'(md_pend_ack));
        if (!rst_in && md_pend_rd) chk("din", 32'(m_din), 32'(md_pend_data));

        // advance to next cycle
        md_pend_ack = (g < 0) ? 2'b00 : (2'b01 << g);
        md_pend_rd  = (g >= 0) && !wr;
        if (g >= 0) begin
            if (wr) begin
                if (io) exp_io[addr[2:0]] = (g == 1) ? m_dout[15:8] : m_dout[7:0];
                else    exp_mem[addr[16:0]] = (g == 1) ? m_dout[15:8] : m_dout[7:0];
            end else begin
                md_pend_data = io ? exp_io[addr[2:0]] : exp_mem[addr[16:0]];
            end
        end
        if (rst_in) begin
            md_locked = 1'b0;
            md_ptr    = 0;
            md_pend_ack = 2'b00;
            md_pend_rd  = 1'b0;
        end else begin
            if (g >= 0 && m_lock[g]) begin
                md_locked = 1'b1;
                md_owner  = g;
            end else if (md_locked && !m_lock[md_owner]) begin
                md_locked = 1'b0;
            end
            if (g >= 0) md_ptr = (g + 1) % 2;
        end
    end

    // Driver: apply one cycle of inputs just after the rising edge
    task automatic drive(input logic rst, input logic rdy, input logic [1:0] req,
                         input logic [1:0] wr, input logic [1:0] lock,
                         input logic [31:0] a0, input logic [31:0] a1,
                         input logic [7:0] d0, input logic [7:0] d1);
        @(posedge clk_in);
        #1;
        rst_in = rst; rdy_in = rdy; m_req = req; m_wr = wr; m_lock = lock;
        m_a = {a1, a0}; m_dout = {d1, d0};
    endtask

    task automatic settle();
        @(negedge clk_in);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 8'h0, 8'h0);
    endtask

    logic [1:0] t4_exp [0:3];
    logic [1:0] t5_req [0:5];
    logic [1:0] t5_lock[0:5];
    logic [1:0] t5_gnt [0:5];

    initial begin
        for (int i = 0; i < 131072; i++) begin
            mem[i]     = 8'(i) ^ 8'h3C;
            exp_mem[i] = 8'(i) ^ 8'h3C;
        end
        for (int i = 0; i < 8; i++) begin
            io_regs[i] = 8'h80 + 8'(i);
            exp_io[i]  = 8'h80 + 8'(i);
        end
        mem[17'h10] = 8'h5A; exp_mem[17'h10] = 8'h5A;
        mem[17'h0]  = 8'h11; exp_mem[17'h0]  = 8'h11;
        io_regs[0]  = 8'h22; exp_io[0]       = 8'h22;
        ram_d_out = 8'h00; io_dout = 8'h00;
        rst_in = 1'b1; rdy_in = 1'b1; m_req = 2'b11; m_wr = 2'b00; m_lock = 2'b00;
        m_a = 64'h0; m_dout = 16'h0;

        // Reset values, with requests pending
        drive(1'b1, 1'b1, 2'b11, 2'b00, 2'b00, 32'h10, 32'h20, 8'h0, 8'h0);
        settle();
        chk("rst_gnt", 32'(m_gnt), 32'd0);
        chk("rst_ack", 32'(m_ack), 32'd0);
        chk("rst_din", 32'(m_din), 32'd0);
        chk("rst_ram_en", 32'(ram_en), 32'd0);
        chk("rst_io_en", 32'(io_en), 32'd0);
        chk("rst_io_wr", 32'(io_wr), 32'd0);
        chk("rst_r_nw", 32'(ram_r_nw), 32'd1);

        // 1: master 0 reads RAM 0x00010
        drive(1'b0, 1'b1, 2'b01, 2'b00, 2'b00, 32'h00010, 32'h0, 8'h0, 8'h0);
        settle();
        chk("t1_gnt", 32'(m_gnt), 32'h1);
        chk("t1_r_nw", 32'(ram_r_nw), 32'd1);
        idle();
        settle();
        chk("t1_ack", 32'(m_ack), 32'h1);
        chk("t1_din", 32'(m_din), 32'h5A);

        // 2: master 1 writes 0xA5 to IO 0x30004
        drive(1'b0, 1'b1, 2'b10, 2'b10, 2'b00, 32'h0, 32'h30004, 8'h0, 8'hA5);
        settle();
        chk("t2_io_en", 32'(io_en), 32'd1);
        chk("t2_io_wr", 32'(io_wr), 32'd1);
        chk("t2_io_sel", 32'(io_sel), 32'd4);
        chk("t2_io_din", 32'(io_din), 32'hA5);
        chk("t2_ram_en", 32'(ram_en), 32'd0);
        idle();
        settle();
        chk("t2_ack", 32'(m_ack), 32'h2);

        // 3: RAM read then IO read back to back
        drive(1'b0, 1'b1, 2'b01, 2'b00, 2'b00, 32'h00000, 32'h0, 8'h0, 8'h0);
        drive(1'b0, 1'b1, 2'b01, 2'b00, 2'b00, 32'h30000, 32'h0, 8'h0, 8'h0);
        settle();
        chk("t3_ack1", 32'(m_ack), 32'h1);
        chk("t3_din1", 32'(m_din), 32'h11);
        idle();
        settle();
        chk("t3_din2", 32'(m_din), 32'h22);

        // 4: both masters request continuously from a fresh pointer
`ifdef MEM_BUS_ARBITER_RR_EN
        t4_exp[0] = 2'b01; t4_exp[1] = 2'b10; t4_exp[2] = 2'b01; t4_exp[3] = 2'b10;
`else
        t4_exp[0] = 2'b01; t4_exp[1] = 2'b01; t4_exp[2] = 2'b01; t4_exp[3] = 2'b01;
`endif
        drive(1'b1, 1'b1, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 8'h0, 8'h0);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 2'b11, 2'b00, 2'b00, 32'h100, 32'h200, 8'h0, 8'h0);
            settle();
            chk($sformatf("t4_gnt%0d", i), 32'(m_gnt), 32'(t4_exp[i]));
        end

        // 5: master 1 locks the bus against master 0
        t5_req[0] = 2'b10; t5_lock[0] = 2'b10; t5_gnt[0] = 2'b10;
        t5_req[1] = 2'b11; t5_lock[1] = 2'b10; t5_gnt[1] = 2'b10;
        t5_req[2] = 2'b11; t5_lock[2] = 2'b10; t5_gnt[2] = 2'b10;
        t5_req[3] = 2'b01; t5_lock[3] = 2'b10; t5_gnt[3] = 2'b00;
        t5_req[4] = 2'b11; t5_lock[4] = 2'b00; t5_gnt[4] = 2'b10;
        t5_req[5] = 2'b11; t5_lock[5] = 2'b00; t5_gnt[5] = 2'b01;
        drive(1'b1, 1'b1, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 8'h0, 8'h0);
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 1'b1, t5_req[i], 2'b00, t5_lock[i], 32'h40, 32'h44, 8'h0, 8'h0);
            settle();
            chk($sformatf("t5_gnt%0d", i), 32'(m_gnt), 32'(t5_gnt[i]));
        end

        // 6: reset right after an issue, then rdy_in low with requests
        drive(1'b0, 1'b1, 2'b01, 2'b00, 2'b00, 32'h10, 32'h0, 8'h0, 8'h0);
        drive(1'b1, 1'b1, 2'b11, 2'b00, 2'b00, 32'h10, 32'h20, 8'h0, 8'h0);
        settle();
        chk("t6_rst_ack", 32'(m_ack), 32'd0);
        chk("t6_rst_gnt", 32'(m_gnt), 32'd0);
        chk("t6_rst_ram_en", 32'(ram_en), 32'd0);
        chk("t6_rst_r_nw", 32'(ram_r_nw), 32'd1);
        chk("t6_rst_din", 32'(m_din), 32'd0);
        drive(1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 8'h0, 8'h0);
        settle();
        chk("t6_post_ack", 32'(m_ack), 32'd0);
        drive(1'b0, 1'b0, 2'b11, 2'b00, 2'b00, 32'h10, 32'h20, 8'h0, 8'h0);
        settle();
        chk("t6_rdy_gnt", 32'(m_gnt), 32'd0);
        chk("t6_rdy_ram_en", 32'(ram_en), 32'd0);
        drive(1'b0, 1'b0, 2'b11, 2'b00, 2'b00, 32'h10, 32'h20, 8'h0, 8'h0);
        settle();
        chk("t6_rdy_ack", 32'(m_ack), 32'd0);

        // 7: rdy_in falling right after an issue still delivers the ack
        drive(1'b0, 1'b1, 2'b10, 2'b00, 2'b00, 32'h0, 32'h10, 8'h0, 8'h0);
        drive(1'b0, 1'b0, 2'b10, 2'b00, 2'b00, 32'h0, 32'h10, 8'h0, 8'h0);
        settle();
        chk("t7_ack", 32'(m_ack), 32'h2);
        chk("t7_din", 32'(m_din), 32'h5A);
        idle();
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
